// File: rtl/qea_host_pkg.sv
// Shared types, default widths and helpers for the QEA host loader.
package qea_host_pkg;

  localparam int DEF_PE_NUM_WIDTH            = 2;
  localparam int DEF_PE_NUM                  = 4;
  localparam int DEF_STATE_DATA_WIDTH        = 64;
  localparam int DEF_STATE_ADDR_WIDTH        = 16;
  localparam int DEF_GATE_CONTEXT_DATA_WIDTH = 64;
  localparam int DEF_GATE_CONTEXT_ADDR_WIDTH = 16;
  localparam int DEF_MAX_QBIT_WIDTH          = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CTX,
    S_LOAD_STATE,
    S_START,
    S_RUN,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_OUT
  } state_t;

  // One row holds 2^pe_w amplitudes, so small circuits still occupy a full row.
  function automatic logic [31:0] rows_from_qbits(input int unsigned qbits,
                                                  input int unsigned pe_w);
    logic [31:0] rows;
    if (qbits <= pe_w) rows = 32'd1;
    else               rows = 32'd1 << (qbits - pe_w);
    return rows;
  endfunction

endpackage

// File: rtl/qea_row_packer.sv
// Packs stream beats into a state row, MSB lane first; o_row/o_row_valid
// present the completed row in the cycle of its last beat.
module qea_row_packer #(
  parameter int PE_NUM       = 4,
  parameter int PE_NUM_WIDTH = 2,
  parameter int DATA_WIDTH   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_beat_valid,
  input  logic [DATA_WIDTH-1:0]        i_beat_data,
  output logic [PE_NUM*DATA_WIDTH-1:0] o_row,
  output logic                         o_row_valid
);

  logic [PE_NUM_WIDTH-1:0]      lane_cnt_reg;
  logic [PE_NUM_WIDTH-1:0]      lane_sel;
  logic [PE_NUM*DATA_WIDTH-1:0] row_reg;
  logic [PE_NUM*DATA_WIDTH-1:0] row_next;

  assign lane_sel = PE_NUM_WIDTH'(PE_NUM - 1) - lane_cnt_reg;

  generate
    for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
      localparam logic [PE_NUM_WIDTH-1:0] LANE = PE_NUM_WIDTH'(gi);
      assign row_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        (i_beat_valid && (lane_sel == LANE)) ? i_beat_data
                                             : row_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign o_row       = row_next;
  assign o_row_valid = i_beat_valid && (lane_cnt_reg == PE_NUM_WIDTH'(PE_NUM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_reg <= '0;
      row_reg      <= '0;
    end else if (i_clear) begin
      lane_cnt_reg <= '0;
    end else if (i_beat_valid) begin
      lane_cnt_reg <= lane_cnt_reg + 1'b1;
      row_reg      <= row_next;
    end
  end

endmodule

// File: rtl/qea_host_loader.sv
// Host-side sequencer for QEA: loads context and state, starts, waits, reads back.
// Optional execution timer on o_cycles is enabled by defining QEA_HOST_TIMER_EN.
module qea_host_loader
  import qea_host_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = DEF_PE_NUM_WIDTH,
  parameter int PE_NUM                  = DEF_PE_NUM,
  parameter int STATE_DATA_WIDTH        = DEF_STATE_DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = DEF_STATE_ADDR_WIDTH,
  parameter int GATE_CONTEXT_DATA_WIDTH = DEF_GATE_CONTEXT_DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = DEF_GATE_CONTEXT_ADDR_WIDTH,
  parameter int MAX_QBIT_WIDTH          = DEF_MAX_QBIT_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic                                 i_s_valid,
  output logic                                 o_s_ready,
  input  logic [63:0]                          i_s_data,
  output logic                                 o_m_valid,
  input  logic                                 i_m_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_m_data,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic                                 o_start,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic [31:0]                          o_cycles
);

  localparam int RW = PE_NUM * STATE_DATA_WIDTH;

  state_t                             state_reg, state_next;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_num_reg, ctx_cnt_reg, ctx_addr_reg;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_reg;
  logic [STATE_ADDR_WIDTH-1:0]        last_row_reg, wr_row_reg, rd_row_reg;
  logic [STATE_ADDR_WIDTH-1:0]        state_addr_reg, rd_addr_next;
  logic [RW-1:0]                      state_din_reg, m_data_reg, packed_row;
  logic ctx_en_reg, state_ena_reg, state_wea_reg, start_reg, arm_reg, done_reg;
  logic s_ready, ctx_hs, st_hs, go_accept, complete_seen, m_hs, last_rd;
  logic rd_req_next, row_valid;

  qea_row_packer #(
    .PE_NUM      (PE_NUM),
    .PE_NUM_WIDTH(PE_NUM_WIDTH),
    .DATA_WIDTH  (STATE_DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (state_reg == S_IDLE),
    .i_beat_valid(st_hs),
    .i_beat_data (STATE_DATA_WIDTH'(i_s_data)),
    .o_row       (packed_row),
    .o_row_valid (row_valid)
  );

  assign s_ready   = (state_reg == S_LOAD_CTX) || (state_reg == S_LOAD_STATE);
  assign ctx_hs    = i_s_valid && (state_reg == S_LOAD_CTX);
  assign st_hs     = i_s_valid && (state_reg == S_LOAD_STATE);
  assign go_accept = i_go && (state_reg == S_IDLE);
  // QEA may still show the previous job's completion right after start.
  assign complete_seen = (state_reg == S_RUN) && i_complete && !start_reg && !arm_reg;
  assign m_hs      = (state_reg == S_RD_OUT) && i_m_ready;
  assign last_rd   = (rd_row_reg == last_row_reg);

  always_comb begin
    state_next   = state_reg;
    rd_addr_next = rd_row_reg;
    case (state_reg)
      S_IDLE:       if (i_go) state_next = (i_ins_num == '0) ? S_LOAD_STATE : S_LOAD_CTX;
      S_LOAD_CTX:   if (ctx_hs && (ctx_cnt_reg == ins_num_reg - 1'b1)) state_next = S_LOAD_STATE;
      S_LOAD_STATE: if (row_valid && (wr_row_reg == last_row_reg)) state_next = S_START;
      S_START:      state_next = S_RUN;
      S_RUN:        if (complete_seen) state_next = S_RD_REQ;
      S_RD_REQ:     state_next = S_RD_WAIT;
      S_RD_WAIT:    state_next = S_RD_OUT;
      S_RD_OUT: begin
        rd_addr_next = rd_row_reg + 1'b1;
        if (m_hs) state_next = last_rd ? S_IDLE : S_RD_REQ;
      end
      default:      state_next = S_IDLE;
    endcase
    rd_req_next = (state_next == S_RD_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      ins_num_reg    <= '0;
      ctx_cnt_reg    <= '0;
      last_row_reg   <= '0;
      wr_row_reg     <= '0;
      rd_row_reg     <= '0;
      ctx_en_reg     <= 1'b0;
      ctx_addr_reg   <= '0;
      ctx_data_reg   <= '0;
      state_ena_reg  <= 1'b0;
      state_wea_reg  <= 1'b0;
      state_addr_reg <= '0;
      state_din_reg  <= '0;
      m_data_reg     <= '0;
      start_reg      <= 1'b0;
      arm_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (go_accept) begin
        ins_num_reg  <= i_ins_num;
        last_row_reg <= STATE_ADDR_WIDTH'(rows_from_qbits(32'(i_qbit_num), PE_NUM_WIDTH) - 32'd1);
        ctx_cnt_reg  <= '0;
        wr_row_reg   <= '0;
        rd_row_reg   <= '0;
      end
      if (ctx_hs)    ctx_cnt_reg <= ctx_cnt_reg + 1'b1;
      if (row_valid) wr_row_reg  <= wr_row_reg + 1'b1;
      if (m_hs)      rd_row_reg  <= rd_row_reg + 1'b1;

      ctx_en_reg <= ctx_hs;
      if (ctx_hs) begin
        ctx_addr_reg <= ctx_cnt_reg;
        ctx_data_reg <= GATE_CONTEXT_DATA_WIDTH'(i_s_data);
      end

      // Row writes and read requests share the single state RAM port.
      state_ena_reg <= row_valid || rd_req_next;
      state_wea_reg <= row_valid;
      if (row_valid) begin
        state_addr_reg <= wr_row_reg;
        state_din_reg  <= packed_row;
      end else if (rd_req_next) begin
        state_addr_reg <= rd_addr_next;
      end

      if (state_reg == S_RD_WAIT) m_data_reg <= i_state_dout;
      start_reg <= (state_reg == S_START);
      arm_reg   <= start_reg;
      done_reg  <= m_hs && last_rd;
    end
  end

`ifdef QEA_HOST_TIMER_EN
  logic [31:0] cycles_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cycles_reg <= '0;
    else if (go_accept)
      cycles_reg <= '0;
    else if ((state_reg == S_RUN) && !complete_seen && (cycles_reg != 32'hFFFF_FFFF))
      cycles_reg <= cycles_reg + 32'd1;
  end
  assign o_cycles = cycles_reg;
`else
  assign o_cycles = 32'd0;
`endif

  assign o_s_ready     = s_ready;
  assign o_m_valid     = (state_reg == S_RD_OUT);
  assign o_m_data      = m_data_reg;
  assign o_ctx_en      = ctx_en_reg;
  assign o_ctx_wea     = ctx_en_reg;
  assign o_ctx_addr    = ctx_addr_reg;
  assign o_ctx_data    = ctx_data_reg;
  assign o_state_ena   = state_ena_reg;
  assign o_state_wea   = state_wea_reg;
  assign o_state_addra = state_addr_reg;
  assign o_state_dina  = state_din_reg;
  assign o_start       = start_reg;
  assign o_busy        = (state_reg != S_IDLE);
  assign o_done        = done_reg;

endmodule

// File: doc/qea_host_loader.md
# qea_host_loader

Hardware host-side driver for the QEA accelerator's load/start/readback interface. It sits between a stream source/sink (DMA or debug bridge) and QEA. It performs the full sequence in order: write gate-context words into the context RAM, pack and write the initial state vector, pulse start, wait for completion, then stream the final state rows out. It replaces bench-driven loading so that circuits can be run on silicon.

## Interface
Parameters:
- PE_NUM_WIDTH, 2, log2 of PE count
- PE_NUM, 4, amplitudes per state row
- STATE_DATA_WIDTH, 64, one complex amplitude (re:im, Q2.30 each)
- STATE_ADDR_WIDTH, 16, state RAM row address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, qubit-count field width

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- i_go  in  1  one-cycle request to run a job; sampled only in IDLE
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_go
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count, latched on accepted i_go
- i_s_valid / o_s_ready / i_s_data  in/out/in  1/1/64  input stream: context words first, then state amplitudes
- o_m_valid / i_m_ready / o_m_data  out/in/out  1/1/PE_NUM*STATE_DATA_WIDTH  output state-row stream
- o_ctx_en, o_ctx_wea  out  1  context RAM write strobe
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH; o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH
- o_state_ena, o_state_wea  out  1  state RAM enable / write enable
- o_state_addra  out  STATE_ADDR_WIDTH; o_state_dina  out  PE_NUM*STATE_DATA_WIDTH
- o_start  out  1  one-cycle start to QEA
- i_complete  in  1  QEA completion (level)
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data, one-cycle latency
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse when the last row is accepted
- o_cycles  out  32  execution cycle count (see Configuration)

## Operation
- FSM states: IDLE → LOAD_CTX → LOAD_STATE → START → RUN → RD_REQ → RD_WAIT → RD_OUT → back to RD_REQ, or to IDLE after the last row.
- IDLE: i_go latches the job parameters, clears the counters, and moves to LOAD_CTX. If i_ins_num==0, the FSM goes directly to LOAD_STATE.
- rows = 2^(i_qbit_num−PE_NUM_WIDTH). If i_qbit_num ≤ PE_NUM_WIDTH, rows = 1.
- LOAD_CTX:
  - o_s_ready=1.
  - Each handshake produces one write: o_ctx_en=o_ctx_wea=1, o_ctx_data=beat, o_ctx_addr=0,1,2,…
  - Exits after i_ins_num beats.
- LOAD_STATE:
  - o_s_ready=1.
  - Beats fill a row register MSB lane first: beat k goes to lane PE_NUM−1−(k mod PE_NUM).
  - On the PE_NUM-th beat, one row write is issued with o_state_ena=o_state_wea=1, address = row index.
  - Exits after rows×PE_NUM beats.
- START: o_start=1 for exactly one cycle.
- RUN: i_complete is ignored in the START cycle and the following cycle. From then on, i_complete=1 moves the FSM to RD_REQ.
- Readback:
  - RD_REQ drives o_state_ena=1, o_state_wea=0, and the address.
  - RD_WAIT captures i_state_dout into the output register.
  - RD_OUT holds o_m_valid=1 with stable o_m_data until i_m_ready.
- i_go outside IDLE is ignored. Stream stalls (i_s_valid=0, i_m_ready=0) insert cycles only; no data is lost or duplicated.

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - o_cycles=0.
  - Reset asserted mid-job aborts immediately; no further strobes are issued.
- o_s_ready is a combinational decode of the state. All RAM strobes and addresses are registered: a write appears one cycle after its accepting beat.
- Latency:
  - i_go to first o_s_ready is 1 cycle.
  - Last load beat to o_start is 2 cycles.
  - i_complete to first o_m_valid is 3 cycles.
- Readback throughput is one row per 3 cycles with i_m_ready held high.
- o_done pulses in the cycle after the last output handshake, together with the return to IDLE.
- Address counters are STATE_ADDR_WIDTH wide. rows beyond 2^STATE_ADDR_WIDTH is a configuration error and is not checked.

## Configuration
- QEA_HOST_TIMER_EN defined: o_cycles counts clocks from the o_start cycle (inclusive) to the first cycle i_complete is seen in RUN (exclusive). The count saturates at 2^32−1 and is held until the next accepted i_go.
- QEA_HOST_TIMER_EN undefined: the counter logic is removed and o_cycles is tied to 0. The port list is unchanged.

## Structure
- A shared package qea_host_pkg holds:
  - the FSM state enum;
  - the default width localparams;
  - a rows_from_qbits function.
- One sub-module, qea_row_packer, performs the beat-to-row lane packing (counter plus row register, emitting a row-valid pulse).

## Test plan
- Context load: i_ins_num=235 with words 0..234 → exactly 235 context writes at addresses 0..234 with matching data, then LOAD_STATE.
- State packing:
  - Stimulus: i_qbit_num=10 and 1024 beats, where the first beat is 64'h40000000_00000000 and the rest are 0.
  - Required: 256 row writes; row 0 lane 3 = 64'h40000000_00000000; all other lanes 0.
- Start/complete: i_complete is asserted 500 cycles after o_start → a single o_start pulse, RD_REQ entered 1 cycle later, o_cycles=500 with the macro and 0 without.
- Readback backpressure:
  - Stimulus: i_m_ready toggles 1/0 every cycle; the RAM model returns address-tagged rows.
  - Required: 256 rows out in address order with no loss and no duplicates, o_m_data stable while stalled, and o_done pulses once.
- Edge cases: i_ins_num=0 skips the context phase. i_qbit_num=2 gives 1 row. i_go during RUN is ignored.
- Reset abort: rst pulsed mid-LOAD_STATE → all outputs are 0 the same cycle; a fresh i_go afterwards completes normally.
